// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with pending-write scoreboard and write-collision flag; define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int DEPTH = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  input  logic [NUM_WR-1:0]      wr_en_i,
  input  logic [NUM_WR*AW-1:0]   wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0] wr_data_i,
  input  logic                   iss_en_i,
  input  logic [AW-1:0]          iss_addr_i,
  input  logic                   flush_i,
  output logic [DEPTH-1:0]       busy_o,
  output logic                   wr_conflict_o
);
  logic [DEPTH-1:0][XLEN-1:0] mem;
  logic [DEPTH-1:0] busy, busy_nxt;
  logic [AW-1:0] wa [NUM_WR];
  logic [XLEN-1:0] wd [NUM_WR];
  logic conflict;
  // unpack the flat write buses into per-port views
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wa[j] = wr_addr_i[j*AW +: AW];
      wd[j] = wr_data_i[j*XLEN +: XLEN];
    end
  end
  // any two enabled ports hitting the same nonzero register
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (wr_en_i[i] && wr_en_i[j] && wa[i] == wa[j] && wa[i] != '0) conflict = 1'b1;
  end
  // scoreboard next state: writeback clears, issue sets over writeback, flush clears everything
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en_i[j]) busy_nxt[wa[j]] = 1'b0;
    if (iss_en_i) busy_nxt[iss_addr_i] = 1'b1;
    if (flush_i) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end
  // storage: later ports overwrite earlier ones, so the highest index wins; x0 is never written
  always_ff @(posedge clk) begin
    if (!rst) mem <= '0;
    else
      for (int j = 0; j < NUM_WR; j++)
        if (wr_en_i[j] && wa[j] != '0) mem[wa[j]] <= wd[j];
  end
  // scoreboard and collision pulse registers
  always_ff @(posedge clk) begin
    busy <= !rst ? '0 : busy_nxt;
    wr_conflict_o <= !rst ? 1'b0 : conflict;
  end
  assign busy_o = busy;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic [XLEN-1:0] d;
    logic b;
    assign a = rd_addr_i[k*AW +: AW];
    // stored contents, optionally replaced by the winning same-cycle write
    always_comb begin
      d = mem[a];
      b = busy[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++)
        if (wr_en_i[j] && a != '0 && wa[j] == a) begin
          d = wd[j];
          b = iss_en_i && iss_addr_i == a;
        end
`endif
    end
    assign rd_data_o[k*XLEN +: XLEN] = d;
    assign rd_busy_o[k] = b;
  end
endmodule
